// File: rtl/tower_build_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tower_build_ctrl_if
// Brief    : Player button inputs and tower-array command/status bundle for
//            tower_build_ctrl. slave = controller side, master = player side.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface tower_build_ctrl_if #(
  parameter int GOLD_W = 12
) ();
  logic              btn_left;
  logic              btn_right;
  logic              btn_type;
  logic              btn_build;
  logic              btn_sell;
  logic              gold_add_valid;
  logic [7:0]        gold_add;
  logic              command_tw;
  logic              build;
  logic              sell;
  logic [2:0]        build_location;
  logic [2:0]        build_type;
  logic [2:0]        cursor;
  logic [2:0]        sel_type;
  logic [GOLD_W-1:0] gold;
  logic [7:0]        occupied;
  logic              err;

  modport slave (
    input  btn_left, btn_right, btn_type, btn_build, btn_sell,
    input  gold_add_valid, gold_add,
    output command_tw, build, sell, build_location, build_type,
    output cursor, sel_type, gold, occupied, err
  );

  modport master (
    output btn_left, btn_right, btn_type, btn_build, btn_sell,
    output gold_add_valid, gold_add,
    input  command_tw, build, sell, build_location, build_type,
    input  cursor, sel_type, gold, occupied, err
  );
endinterface
`default_nettype wire

// File: rtl/tower_build_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tower_build_ctrl
// Brief    : Player command stage ahead of the tower slot array. Edge-detects
//            buttons, tracks cursor/type, owns the gold ledger and per-slot
//            tower types, and issues single-cycle build/sell commands.
//            Optional macro TOWER_CTRL_REFUND_EN: sells refund half the cost
//            of the tower being sold (otherwise refund is 0).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tower_build_ctrl #(
  parameter int START_GOLD = 200,
  parameter int GOLD_W     = 12,
  parameter int COST1      = 100,
  parameter int COST2      = 120,
  parameter int COST3      = 160,
  parameter int COST4      = 220
) (
  input  logic               Clk,
  input  logic               Reset,
  tower_build_ctrl_if.slave  bus
);

  // Two guard bits above the ledger so sums never wrap before saturation.
  localparam int GW = GOLD_W + 2;
  localparam logic [GW-1:0] GOLD_MAX = {2'b00, {GOLD_W{1'b1}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  function automatic logic [GW-1:0] cost_of(input logic [2:0] t);
    case (t)
      3'd1:    cost_of = GW'(COST1);
      3'd2:    cost_of = GW'(COST2);
      3'd3:    cost_of = GW'(COST3);
      3'd4:    cost_of = GW'(COST4);
      default: cost_of = '0;
    endcase
  endfunction

  logic [1:0]        state;
  logic [4:0]        btn_now, btn_prev, rise;
  logic [2:0]        cursor_q, sel_type_q;
  logic [2:0]        slot_q, type_q;
  logic              op_build_q;
  logic [GOLD_W-1:0] gold_q;
  logic [2:0]        slot_type [8];
  logic              cmd_q, build_q, sell_q, err_q;

  logic [GW-1:0]     cost, refund, debit, credit, income, gold_wide, sum;
  logic [GOLD_W-1:0] gold_next;
  logic              slot_busy, legal, commit;

  // Bit order: left, right, type, build, sell
  assign btn_now = {bus.btn_left, bus.btn_right, bus.btn_type, bus.btn_build, bus.btn_sell};
  assign rise    = btn_now & ~btn_prev;

  assign cost      = cost_of(type_q);
  assign slot_busy = (slot_type[slot_q] != 3'd0);
  assign gold_wide = {2'b00, gold_q};
  // Affordability uses the registered ledger only, never same-cycle income.
  assign legal     = op_build_q ? (!slot_busy && (gold_wide >= cost)) : slot_busy;
  assign commit    = (state == S_CHECK) && legal;

`ifdef TOWER_CTRL_REFUND_EN
  assign refund = cost_of(slot_type[slot_q]) >> 1;
`else
  assign refund = '0;
`endif

  // Income, debit and refund combine into one saturating ledger update; the
  // debit cannot underflow because CHECK already proved gold >= cost.
  assign debit     = (commit && op_build_q)  ? cost   : '0;
  assign credit    = (commit && !op_build_q) ? refund : '0;
  assign income    = bus.gold_add_valid ? GW'(bus.gold_add) : '0;
  assign sum       = gold_wide + income + credit - debit;
  assign gold_next = (sum > GOLD_MAX) ? GOLD_MAX[GOLD_W-1:0] : sum[GOLD_W-1:0];

  // Button history for rising-edge detection; cleared by reset so a held
  // button fires on the first edge after reset.
  always_ff @(posedge Clk) begin
    if (Reset) btn_prev <= '0;
    else       btn_prev <= btn_now;
  end

  // Cursor and type selection respond in every FSM state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cursor_q   <= 3'd0;
      sel_type_q <= 3'd1;
    end else begin
      if (rise[4] && !rise[3])      cursor_q <= cursor_q - 3'd1;
      else if (rise[3] && !rise[4]) cursor_q <= cursor_q + 3'd1;
      if (rise[2]) sel_type_q <= (sel_type_q == 3'd4) ? 3'd1 : sel_type_q + 3'd1;
    end
  end

  // Command FSM: latch target at acceptance, decide in CHECK, strobe in ISSUE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      slot_q     <= 3'd0;
      type_q     <= 3'd0;
      op_build_q <= 1'b0;
      cmd_q      <= 1'b0;
      build_q    <= 1'b0;
      sell_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cmd_q   <= 1'b0;
      build_q <= 1'b0;
      sell_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise[1] || rise[0]) begin
            state      <= S_CHECK;
            op_build_q <= rise[1];
            slot_q     <= cursor_q;
            type_q     <= sel_type_q;
          end
        end
        S_CHECK: begin
          if (legal) begin
            state   <= S_ISSUE;
            cmd_q   <= 1'b1;
            build_q <= op_build_q;
            sell_q  <= !op_build_q;
          end else begin
            state <= S_IDLE;
            err_q <= 1'b1;
          end
        end
        S_ISSUE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ledger and slot table; a slot's type doubles as its occupancy flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gold_q <= GOLD_W'(START_GOLD);
      for (int i = 0; i < 8; i++) slot_type[i] <= 3'd0;
    end else begin
      gold_q <= gold_next;
      if (commit) slot_type[slot_q] <= op_build_q ? type_q : 3'd0;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_occ
    assign bus.occupied[i] = (slot_type[i] != 3'd0);
  end

  assign bus.command_tw     = cmd_q;
  assign bus.build          = build_q;
  assign bus.sell           = sell_q;
  assign bus.err            = err_q;
  assign bus.build_location = slot_q;
  assign bus.build_type     = type_q;
  assign bus.cursor         = cursor_q;
  assign bus.sel_type       = sel_type_q;
  assign bus.gold           = gold_q;

endmodule
`default_nettype wire

// File: tb/tb_tower_build_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_tower_build_ctrl
// Brief    : Self-checking bench for tower_build_ctrl: directed vector table,
//            hand-written corner sequences and random stimulus against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_tower_build_ctrl;
  localparam int GOLD_W = 12;
  localparam int GMAX   = 4095;
`ifdef TOWER_CTRL_REFUND_EN
  localparam int REFUND_ON = 1;
`else
  localparam int REFUND_ON = 0;
`endif

  logic Clk;
  logic Reset;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  tower_build_ctrl_if #(.GOLD_W(GOLD_W)) bus ();

  tower_build_ctrl #(
    .START_GOLD(200), .GOLD_W(GOLD_W),
    .COST1(100), .COST2(120), .COST3(160), .COST4(220)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state (spec-level quantities only)
  int       m_gold, m_cur, m_sel, m_busy, m_pslot, m_ptype;
  int       m_slot [8];
  bit       m_pend, m_pbuild;
  bit [4:0] m_prev;
  bit       e_cmd, e_b, e_s, e_err;
  int       e_loc, e_typ;

  function automatic int cost(input int t);
    case (t)
      1: return 100;
      2: return 120;
      3: return 160;
      4: return 220;
      default: return 0;
    endcase
  endfunction

  function automatic int refund(input int t);
    return REFUND_ON ? cost(t) / 2 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs applied before it.
  task automatic m_step(input bit rst, input bit [4:0] btn, input bit iv, input int ia);
    bit [4:0] r;
    int debit, credit;
    bit legal;
    e_cmd = 0; e_b = 0; e_s = 0; e_err = 0;
    if (rst) begin
      m_gold = 200; m_cur = 0; m_sel = 1; m_busy = 0; m_pend = 0; m_prev = '0;
      foreach (m_slot[i]) m_slot[i] = 0;
      return;
    end
    r = btn & ~m_prev;
    m_prev = btn;
    debit = 0; credit = 0;
    if (m_pend) begin
      m_pend = 0;
      legal = m_pbuild ? (m_slot[m_pslot] == 0 && m_gold >= cost(m_ptype))
                       : (m_slot[m_pslot] != 0);
      if (legal) begin
        e_cmd = 1; e_b = m_pbuild; e_s = !m_pbuild; e_loc = m_pslot; e_typ = m_ptype;
        m_busy = 1;
        if (m_pbuild) begin
          debit = cost(m_ptype);
          m_slot[m_pslot] = m_ptype;
        end else begin
          credit = refund(m_slot[m_pslot]);
          m_slot[m_pslot] = 0;
        end
      end else begin
        e_err = 1;
      end
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (r[1] || r[0]) begin
      m_pend = 1; m_pbuild = r[1]; m_pslot = m_cur; m_ptype = m_sel;
    end
    m_gold = m_gold + (iv ? ia : 0) + credit - debit;
    if (m_gold > GMAX) m_gold = GMAX;
    if (r[4] && !r[3])      m_cur = (m_cur + 7) % 8;
    else if (r[3] && !r[4]) m_cur = (m_cur + 1) % 8;
    if (r[2]) m_sel = (m_sel == 4) ? 1 : m_sel + 1;
  endtask

  // Drive one cycle of inputs, clock it, and compare DUT against the model.
  task automatic cycle(input bit rst, input bit [4:0] btn, input bit iv, input bit [7:0] ia);
    int occ;
    Reset              = rst;
    bus.btn_left       = btn[4];
    bus.btn_right      = btn[3];
    bus.btn_type       = btn[2];
    bus.btn_build      = btn[1];
    bus.btn_sell       = btn[0];
    bus.gold_add_valid = iv;
    bus.gold_add       = ia;
    m_step(rst, btn, iv, int'(ia));
    @(posedge Clk);
    #1;
    occ = 0;
    for (int i = 0; i < 8; i++) if (m_slot[i] != 0) occ |= (1 << i);
    chk("m_gold",     int'(bus.gold),       m_gold);
    chk("m_occupied", int'(bus.occupied),   occ);
    chk("m_cursor",   int'(bus.cursor),     m_cur);
    chk("m_sel_type", int'(bus.sel_type),   m_sel);
    chk("m_cmd",      int'(bus.command_tw), int'(e_cmd));
    chk("m_build",    int'(bus.build),      int'(e_b));
    chk("m_sell",     int'(bus.sell),       int'(e_s));
    chk("m_err",      int'(bus.err),        int'(e_err));
    if (e_cmd) chk("m_location", int'(bus.build_location), e_loc);
    if (e_b)   chk("m_btype",    int'(bus.build_type),     e_typ);
  endtask

  task automatic press(input bit [4:0] btn);
    cycle(1'b0, btn, 1'b0, 8'd0);
    cycle(1'b0, 5'd0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 5'd0, 1'b0, 8'd0);
    cycle(1'b1, 5'd0, 1'b0, 8'd0);
  endtask

  typedef struct {
    bit [4:0] btn;
    bit       iv;
    bit [7:0] ia;
    int       g, occ, cur, st;
    bit       cmd, bl, sl, er;
    int       loc, typ;
  } vec_t;

  function automatic vec_t mk(input bit [4:0] btn, input bit iv, input bit [7:0] ia,
                              input int g, input int occ, input int cur, input int st,
                              input bit cmd, input bit bl, input bit sl, input bit er,
                              input int loc, input int typ);
    vec_t v;
    v.btn = btn; v.iv = iv; v.ia = ia; v.g = g; v.occ = occ; v.cur = cur; v.st = st;
    v.cmd = cmd; v.bl = bl; v.sl = sl; v.er = er; v.loc = loc; v.typ = typ;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   r1, r2;
    bit [4:0] rb;
    r1 = REFUND_ON ? 50 : 0;
    r2 = REFUND_ON ? 60 : 0;

    Reset = 1'b1;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_type = 0;
    bus.btn_build = 0; bus.btn_sell = 0; bus.gold_add_valid = 0; bus.gold_add = '0;

    // ---------------- reset values ----------------
    do_reset();
    chk("rst_gold",     int'(bus.gold), 200);
    chk("rst_cursor",   int'(bus.cursor), 0);
    chk("rst_sel_type", int'(bus.sel_type), 1);
    chk("rst_occupied", int'(bus.occupied), 0);
    chk("rst_strobes",  int'({bus.command_tw, bus.build, bus.sell, bus.err}), 0);
    chk("rst_loc_type", int'({bus.build_location, bus.build_type}), 0);

    // ---------------- directed vector table ----------------
    //              btn       iv ia  gold   occ    cur st cmd b s e loc typ
    tbl.push_back(mk(5'b00010, 0, 0, 200,    'h00,  0, 1, 0, 0, 0, 0, 0, 0)); // build slot0 t1
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00100, 0, 0, 100,    'h01,  0, 2, 0, 0, 0, 0, 0, 0)); // type 2
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00100, 0, 0, 100,    'h01,  0, 3, 0, 0, 0, 0, 0, 0)); // type 3
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00100, 0, 0, 100,    'h01,  0, 4, 0, 0, 0, 0, 0, 0)); // type 4
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  0, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b01000, 0, 0, 100,    'h01,  1, 4, 0, 0, 0, 0, 0, 0)); // cursor 1
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  1, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00010, 0, 0, 100,    'h01,  1, 4, 0, 0, 0, 0, 0, 0)); // unaffordable t4
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  1, 4, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  1, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b10000, 0, 0, 100,    'h01,  0, 4, 0, 0, 0, 0, 0, 0)); // left 1->0
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  0, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b10000, 0, 0, 100,    'h01,  7, 4, 0, 0, 0, 0, 0, 0)); // left 0->7
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  7, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b11000, 0, 0, 100,    'h01,  7, 4, 0, 0, 0, 0, 0, 0)); // cancel
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  7, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00100, 0, 0, 100,    'h01,  7, 1, 0, 0, 0, 0, 0, 0)); // type 4->1
    tbl.push_back(mk(5'b00000, 0, 0, 100,    'h01,  7, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00011, 0, 0, 100,    'h01,  7, 1, 0, 0, 0, 0, 0, 0)); // build+sell
    tbl.push_back(mk(5'b00000, 0, 0, 0,      'h81,  7, 1, 1, 1, 0, 0, 7, 1));
    tbl.push_back(mk(5'b00001, 0, 0, 0,      'h81,  7, 1, 0, 0, 0, 0, 0, 0)); // dropped sell
    tbl.push_back(mk(5'b00000, 1, 30, 30,    'h81,  7, 1, 0, 0, 0, 0, 0, 0)); // income
    tbl.push_back(mk(5'b00001, 0, 0, 30,     'h81,  7, 1, 0, 0, 0, 0, 0, 0)); // sell slot7
    tbl.push_back(mk(5'b00000, 0, 0, 30+r1,  'h01,  7, 1, 1, 0, 1, 0, 7, 0));
    tbl.push_back(mk(5'b00000, 0, 0, 30+r1,  'h01,  7, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00001, 0, 0, 30+r1,  'h01,  7, 1, 0, 0, 0, 0, 0, 0)); // sell empty
    tbl.push_back(mk(5'b00000, 0, 0, 30+r1,  'h01,  7, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0, 30+r1,  'h01,  7, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b01000, 0, 0, 30+r1,  'h01,  0, 1, 0, 0, 0, 0, 0, 0)); // right 7->0
    tbl.push_back(mk(5'b00000, 0, 0, 30+r1,  'h01,  0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00010, 0, 0, 30+r1,  'h01,  0, 1, 0, 0, 0, 0, 0, 0)); // build occupied
    tbl.push_back(mk(5'b00000, 0, 0, 30+r1,  'h01,  0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0, 30+r1,  'h01,  0, 1, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      cycle(1'b0, tbl[i].btn, tbl[i].iv, tbl[i].ia);
      chk($sformatf("row%0d_gold", i),     int'(bus.gold),       tbl[i].g);
      chk($sformatf("row%0d_occupied", i), int'(bus.occupied),   tbl[i].occ);
      chk($sformatf("row%0d_cursor", i),   int'(bus.cursor),     tbl[i].cur);
      chk($sformatf("row%0d_sel_type", i), int'(bus.sel_type),   tbl[i].st);
      chk($sformatf("row%0d_cmd", i),      int'(bus.command_tw), int'(tbl[i].cmd));
      chk($sformatf("row%0d_build", i),    int'(bus.build),      int'(tbl[i].bl));
      chk($sformatf("row%0d_sell", i),     int'(bus.sell),       int'(tbl[i].sl));
      chk($sformatf("row%0d_err", i),      int'(bus.err),        int'(tbl[i].er));
      if (tbl[i].cmd) chk($sformatf("row%0d_loc", i), int'(bus.build_location), tbl[i].loc);
      if (tbl[i].bl)  chk($sformatf("row%0d_type", i), int'(bus.build_type), tbl[i].typ);
    end

    // ---------------- button held through reset fires once ----------------
    cycle(1'b1, 5'b00010, 1'b0, 8'd0);
    cycle(1'b1, 5'b00010, 1'b0, 8'd0);
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    chk("held_check_cmd", int'(bus.command_tw), 0);
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    chk("held_issue_cmd", int'(bus.command_tw), 1);
    chk("held_gold",      int'(bus.gold), 100);
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    chk("held_no_repeat", int'(bus.command_tw), 0);

    // ---------------- reset during CHECK aborts ----------------
    do_reset();
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    cycle(1'b1, 5'b00000, 1'b0, 8'd0);
    chk("abort_gold", int'(bus.gold), 200);
    chk("abort_occ",  int'(bus.occupied), 0);
    chk("abort_cmd",  int'(bus.command_tw), 0);
    cycle(1'b0, 5'b00000, 1'b0, 8'd0);
    chk("abort_after", int'({bus.command_tw, bus.err}), 0);

    // ---------------- ledger saturation ----------------
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1'b0, 5'd0, 1'b1, 8'd255);
    cycle(1'b0, 5'd0, 1'b1, 8'd65);
    chk("sat_4090", int'(bus.gold), 4090);
    cycle(1'b0, 5'd0, 1'b1, 8'd20);
    chk("sat_4095", int'(bus.gold), 4095);

    // ---------------- income coinciding with a debit ----------------
    do_reset();
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    cycle(1'b0, 5'b00000, 1'b0, 8'd0);
    cycle(1'b0, 5'b00000, 1'b1, 8'd50);
    chk("net_pre_gold", int'(bus.gold), 150);
    press(5'b01000);
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    cycle(1'b0, 5'b00000, 1'b1, 8'd30);
    chk("net_gold", int'(bus.gold), 80);
    chk("net_cmd",  int'(bus.command_tw), 1);
    chk("net_loc",  int'(bus.build_location), 1);
    cycle(1'b0, 5'b00000, 1'b0, 8'd0);

    // ---------------- build type 2 on slot 3, then sell it ----------------
    do_reset();
    press(5'b00100);
    press(5'b01000); press(5'b01000); press(5'b01000);
    cycle(1'b0, 5'b00010, 1'b0, 8'd0);
    cycle(1'b0, 5'b00000, 1'b0, 8'd0);
    chk("t2_build_gold", int'(bus.gold), 80);
    chk("t2_build_occ",  int'(bus.occupied), 'h08);
    chk("t2_build_type", int'(bus.build_type), 2);
    cycle(1'b0, 5'b00000, 1'b0, 8'd0);
    cycle(1'b0, 5'b00001, 1'b0, 8'd0);
    cycle(1'b0, 5'b00000, 1'b0, 8'd0);
    chk("t2_sell",      int'(bus.sell), 1);
    chk("t2_sell_loc",  int'(bus.build_location), 3);
    chk("t2_sell_gold", int'(bus.gold), 80 + r2);
    chk("t2_sell_occ",  int'(bus.occupied), 0);
    cycle(1'b0, 5'b00000, 1'b0, 8'd0);

    // ---------------- random stimulus against the model ----------------
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 5; b++) rb[b] = ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 499) == 0, rb, $urandom_range(0, 7) == 0,
            8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
